seq_multiplier_32: RTL and testbench
====================================

SEQ_MULTIPLIER_32 -- requirements
Module: seq_multiplier_32

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset, listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 is_signed  input  1  two's-complement operands when 1; sampled with start.
REQ-006 a  input  32  multiplicand; sampled with start.
REQ-007 b  input  32  multiplier; sampled with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-009 done  output  1  one-cycle pulse; product is valid in the same cycle.
REQ-010 product  output  64  result; held stable from done until the next accepted start.

Function
REQ-011 States SHALL be IDLE, CALC, NEG and DONE.
REQ-012 IDLE with start=1 SHALL latch the operands, clear the high accumulator and count, and move to CALC; call this cycle T.
REQ-013 Signed load: with the macro enabled and is_signed=1, each negative operand SHALL be replaced by its magnitude, and neg_flag = a[31]^b[31] SHALL be stored.
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
REQ-014 Each CALC cycle SHALL do the following:
- If multiplier[0]=1, add the multiplicand to the high accumulator through the 32-bit adder with cin=0; otherwise add zero.
- Shift {cout, acc_hi, multiplier} right by one.
- Increment the 5-bit count.
REQ-015 CALC SHALL run exactly 32 cycles; it exits when count wraps from 31 to 0.
REQ-016 From CALC, the next state SHALL be NEG when signed mode is active, else DONE.
REQ-017 NEG (1 cycle) SHALL two's-complement negate the 64-bit product if neg_flag=1, else leave it unchanged.
REQ-018 done SHALL assert in DONE, in cycle T+33 for unsigned and T+34 for signed, then return to IDLE.
REQ-019 start while not in IDLE (including the DONE cycle) SHALL be ignored and operands not resampled.
REQ-020 start in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back throughput: one result per 34/35 cycles).
REQ-021 product SHALL only update in CALC/NEG; between operations it holds the last result.
REQ-022 Operands of zero SHALL still take the full latency; there is no early termination.

Reset
REQ-023 rst_n low SHALL immediately force the following, regardless of state (mid-operation aborts, no done):
- state=IDLE, busy=0, done=0, product=0, count=0, neg_flag=0.
REQ-024 The first start SHALL be accepted in the first clock edge with rst_n high.

Configuration
REQ-025 Macro MUL_SIGNED_EN SHALL control signed support.
- Defined: behaviour per REQ-013/016/017.
- Undefined: is_signed is ignored, the NEG state and magnitude logic are not built, and all operations are unsigned with done at T+33.

Structure
REQ-026 Shared package mul_pkg SHALL hold the following; no other module redefines them:
- MUL_W=32
- CNT_W=5
- state encoding localparams: IDLE=2'd0, CALC=2'd1, NEG=2'd2, DONE=2'd3
REQ-027 Exactly one sub-module SHALL be instantiated: the team's 32-bit adder prefixadder_32, used for the CALC accumulate.
- NEG negation uses local logic.

Verification
REQ-028 Unsigned small: a=7, b=6, start at T -> busy=1 from T+1, done at T+33, product=0x000000000000002A.
REQ-029 Unsigned max: a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 with done at T+33; checks the cout path.
REQ-030 Signed (MUL_SIGNED_EN): a=0xFFFFFFFD (-3), b=5, is_signed=1 -> done at T+34, product=0xFFFFFFFFFFFFFFF1.
- Also a=b=0x80000000 -> 0x4000000000000000.
REQ-031 Busy protection: start pulsed at T+10 with a=1, b=1 during a 7*6 operation -> ignored, result 42, single done.
REQ-032 Reset mid-op: rst_n low at T+15 -> outputs zero immediately, no done.
- New start after release -> correct result with full latency.
REQ-033 Back-to-back: start held high continuously -> the next operation is accepted the cycle after done, with no lost or duplicate done pulses.

Source files
------------

// File: rtl/seq_multiplier_32_pkg.sv
// Shared constants for the 32x32 sequential shift-add multiplier: widths,
// state encoding and the operand magnitude helper.
package mul_pkg;

    localparam int MUL_W  = 32;
    localparam int CNT_W  = 5;
    localparam int PROD_W = 2 * MUL_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] NEG  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [MUL_W-1:0] magnitude(input logic [MUL_W-1:0] v);
        return v[MUL_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/seq_multiplier_32_if.sv
// Request/result bundle of the sequential multiplier; the requester drives
// the master modport, the multiplier implements the slave modport.
interface seq_multiplier_32_if;
    import mul_pkg::*;

    logic              start;
    logic              is_signed;
    logic [MUL_W-1:0]  a;
    logic [MUL_W-1:0]  b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] product;

    modport master (output start, is_signed, a, b, input busy, done, product);
    modport slave  (input start, is_signed, a, b, output busy, done, product);

endinterface

// File: rtl/prefixadder_32.sv
// 32-bit Kogge-Stone prefix adder with carry-in and carry-out.
module prefixadder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] prop;
    logic [31:0] grp_g;
    logic [31:0] grp_p;
    logic [32:0] carry;

    assign prop = a ^ b;

    // Five doubling levels; after level k each bit holds the group
    // generate/propagate of the 2^(k+1) bits ending at that position.
    always_comb begin
        logic [31:0] g_cur;
        logic [31:0] p_cur;
        logic [31:0] g_nxt;
        logic [31:0] p_nxt;
        g_cur = a & b;
        p_cur = prop;
        g_nxt = '0;
        p_nxt = '0;
        for (int lvl = 0; lvl < 5; lvl++) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = 0; i < 32; i++) begin
                if (i >= (1 << lvl)) begin
                    g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << lvl)]);
                    p_nxt[i] = p_cur[i] & p_cur[i - (1 << lvl)];
                end
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        grp_g = g_cur;
        grp_p = p_cur;
    end

    assign carry = {grp_g | (grp_p & {32{cin}}), cin};

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sum
            assign sum[gi] = prop[gi] ^ carry[gi];
        end
    endgenerate

    assign cout = carry[32];

endmodule

// File: rtl/seq_multiplier_32.sv
// Radix-2 shift-add 32x32 multiplier, one partial product per cycle.
// Signed operands are supported only when MUL_SIGNED_EN is defined.
module seq_multiplier_32
    import mul_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    seq_multiplier_32_if.slave  bus
);

    logic [1:0]        state_reg;
    logic [MUL_W-1:0]  mcand_reg;
    logic [MUL_W-1:0]  mplier_reg;
    logic [MUL_W-1:0]  acc_hi_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PROD_W-1:0] product_reg;

    logic [MUL_W-1:0]  load_a;
    logic [MUL_W-1:0]  load_b;
    logic [MUL_W-1:0]  addend;
    logic [MUL_W-1:0]  add_sum;
    logic              add_cout;
    logic [MUL_W-1:0]  acc_hi_next;
    logic [MUL_W-1:0]  mplier_next;

`ifdef MUL_SIGNED_EN
    logic signed_reg;
    logic neg_flag_reg;

    assign load_a = bus.is_signed ? magnitude(bus.a) : bus.a;
    assign load_b = bus.is_signed ? magnitude(bus.b) : bus.b;
`else
    assign load_a = bus.a;
    assign load_b = bus.b;
`endif

    assign addend = mplier_reg[0] ? mcand_reg : '0;

    prefixadder_32 u_adder (
        .a    (acc_hi_reg),
        .b    (addend),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // {cout, acc_hi, multiplier} shifted right by one; the retired multiplier
    // bits make room for the low half of the product.
    assign acc_hi_next = {add_cout, add_sum[MUL_W-1:1]};
    assign mplier_next = {add_sum[0], mplier_reg[MUL_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            acc_hi_reg   <= '0;
            count_reg    <= '0;
            product_reg  <= '0;
`ifdef MUL_SIGNED_EN
            signed_reg   <= 1'b0;
            neg_flag_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        mcand_reg    <= load_a;
                        mplier_reg   <= load_b;
                        acc_hi_reg   <= '0;
                        count_reg    <= '0;
`ifdef MUL_SIGNED_EN
                        signed_reg   <= bus.is_signed;
                        neg_flag_reg <= bus.is_signed & (bus.a[MUL_W-1] ^ bus.b[MUL_W-1]);
`endif
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    acc_hi_reg <= acc_hi_next;
                    mplier_reg <= mplier_next;
                    count_reg  <= count_reg + 1'b1;
                    if (count_reg == {CNT_W{1'b1}}) begin
                        product_reg <= {acc_hi_next, mplier_next};
`ifdef MUL_SIGNED_EN
                        state_reg   <= signed_reg ? NEG : DONE;
`else
                        state_reg   <= DONE;
`endif
                    end
                end
`ifdef MUL_SIGNED_EN
                NEG: begin
                    if (neg_flag_reg) begin
                        product_reg <= -product_reg;
                    end
                    state_reg <= DONE;
                end
`endif
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.done    = (state_reg == DONE);
    assign bus.product = product_reg;

endmodule

// File: tb/tb_seq_multiplier_32.sv
// Scoreboard bench for seq_multiplier_32: the driver queues expected product,
// accept cycle and latency; a monitor checks each done pulse against the queue.
module tb_seq_multiplier_32;

`ifdef MUL_SIGNED_EN
    localparam int LAT_S = 34;
`else
    localparam int LAT_S = 33;
`endif
    localparam int LAT_U = 33;

    typedef struct {
        logic [63:0] prod;
        int          t;
        int          lat;
    } sb_entry_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    sb_entry_t sb[$];

    seq_multiplier_32_if bus ();

    seq_multiplier_32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        sb_entry_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("product", bus.product, e.prod);
                chk("latency", 64'(cyc - e.t), 64'(e.lat));
                chk("busy_at_done", 64'(bus.busy), 64'd1);
                $display("done: product=0x%016h latency=%0d", bus.product, cyc - e.t);
            end
        end
    end

    task automatic wait_idle();
        int w;
        w = 0;
        while (bus.busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (bus.busy) chk("idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    // Call on a negedge; returns on the negedge of cycle T+1.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic s,
                         input logic [63:0] ep, input int lat);
        wait_idle();
        bus.a         = ia;
        bus.b         = ib;
        bus.is_signed = s;
        bus.start     = 1'b1;
        sb.push_back('{ep, cyc, lat});
        $display("issue: a=0x%08h b=0x%08h signed=%0d expect=0x%016h", ia, ib, s, ep);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_t1", 64'(bus.busy), 64'd1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
    endtask

    initial begin
        int t0;
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_product", bus.product, 64'd0);

        // First start coincides with the first edge after reset release
        rst_n = 1'b1;
        issue(32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, LAT_U);
        drain();
        repeat (3) @(negedge clk);
        chk("product_hold", bus.product, 64'h2A);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, LAT_U);
        issue(32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0, LAT_U);
        issue(32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780, LAT_U);
        issue(32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000, LAT_U);
`ifdef MUL_SIGNED_EN
        issue(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, LAT_S);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, LAT_S);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, LAT_S);
        issue(32'd7, 32'hFFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, LAT_S);
`else
        issue(32'hFFFF_FFFD, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1, LAT_S);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, LAT_S);
`endif
        drain();

        // Start pulse during an operation must be ignored
        issue(32'd7, 32'd6, 1'b0, 64'h2A, LAT_U);
        repeat (9) @(negedge clk);
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        chk("ignored_start_product", bus.product, 64'h2A);

        // Reset in the middle of an operation
        issue(32'd7, 32'd6, 1'b0, 64'h2A, LAT_U);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_done", 64'(bus.done), 64'd0);
        chk("midreset_product", bus.product, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(32'd9, 32'd11, 1'b0, 64'h63, LAT_U);
        drain();

        // Start held high: next accept is the IDLE cycle right after done
        wait_idle();
        t0            = cyc;
        bus.a         = 32'd3;
        bus.b         = 32'd4;
        bus.is_signed = 1'b0;
        bus.start     = 1'b1;
        sb.push_back('{64'd12, t0, LAT_U});
        sb.push_back('{64'h2710, t0 + LAT_U + 1, LAT_U});
        sb.push_back('{64'hFFFE_0001, t0 + 2 * (LAT_U + 1), LAT_U});
        $display("issue: back-to-back 3*4, 100*100, 0xFFFF*0xFFFF with start held");
        @(negedge clk);
        bus.a = 32'd100;
        bus.b = 32'd100;
        repeat (LAT_U + 1) @(negedge clk);
        bus.a = 32'h0000_FFFF;
        bus.b = 32'h0000_FFFF;
        repeat (LAT_U + 1) @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        chk("b2b_final_product", bus.product, 64'hFFFE_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
